// File: rtl/stream_parity_gen.sv
// Streaming per-word parity generator with one column-parity (LRC) trailer word
// appended to each frame; frames reaching MAX_WORDS are force-closed as truncated.
module stream_parity_gen #(
    parameter int WIDTH     = 8,
    parameter bit ODD       = 1'b1,
    parameter int MAX_WORDS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             out_trailer,
    output logic             out_trunc
);

    localparam int CW = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WORDS - 1);

    typedef enum logic {
        PASS,
        TRAILER
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] trl;
    logic [CW-1:0]    cnt;
    logic             trunc;
    logic             slot_free;
    logic             rdy;
    logic             load_data;
    logic             load_trl;
    logic             close;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = rdy;

    // Parity is derived from the held word, so it stays stable under backpressure.
    assign out_par   = (^out_data) ^ ODD;

    always_ff @(posedge clk) begin
        if (rst) state <= PASS;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        load_data = 1'b0;
        load_trl  = 1'b0;
        close     = 1'b0;
        case (state)
            PASS: begin
                rdy       = slot_free && !rst;
                load_data = in_valid && rdy;
                close     = load_data && (in_last || cnt == CNT_LAST);
                if (close) state_nxt = TRAILER;
            end
            TRAILER: begin
                load_trl = slot_free;
                if (slot_free) state_nxt = PASS;
            end
            default: state_nxt = PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_trailer <= 1'b0;
            out_trunc   <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            trl         <= '0;
            trunc       <= 1'b0;
        end else begin
            if (load_data) begin
                out_valid   <= 1'b1;
                out_data    <= in_data;
                out_last    <= 1'b0;
                out_trailer <= 1'b0;
                out_trunc   <= 1'b0;
            end else if (load_trl) begin
                out_valid   <= 1'b1;
                out_data    <= trl;
                out_last    <= 1'b1;
                out_trailer <= 1'b1;
                out_trunc   <= trunc;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end

            // Inverting the LRC for odd sense makes each column, trailer included, odd.
            if (close) begin
                trl   <= (acc ^ in_data) ^ {WIDTH{ODD}};
                trunc <= !in_last;
                acc   <= '0;
                cnt   <= '0;
            end else if (load_data) begin
                acc   <= acc ^ in_data;
                cnt   <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_parity_gen.sv
// Directed vector table on two small-frame instances (odd/even) plus a
// randomized scoreboard run on a MAX_WORDS=16 instance.
module tb_stream_parity_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instances 0 (odd) and 1 (even) share stimulus; only sense differs.
    logic [7:0] in_data;
    logic       in_valid, in_last, out_ready;
    logic       rdy0, vld0, par0, last0, trl0, trunc0;
    logic       rdy1, vld1, par1, last1, trl1, trunc1;
    logic [7:0] dat0, dat1;

    stream_parity_gen #(.WIDTH(8), .ODD(1'b1), .MAX_WORDS(4)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy0), .out_data(dat0), .out_par(par0), .out_valid(vld0),
        .out_ready(out_ready), .out_last(last0), .out_trailer(trl0), .out_trunc(trunc0));

    stream_parity_gen #(.WIDTH(8), .ODD(1'b0), .MAX_WORDS(4)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy1), .out_data(dat1), .out_par(par1), .out_valid(vld1),
        .out_ready(out_ready), .out_last(last1), .out_trailer(trl1), .out_trunc(trunc1));

    logic [7:0] r_in_data, r_dat;
    logic       r_in_valid, r_in_last, r_out_ready;
    logic       r_rdy, r_vld, r_par, r_last, r_trl, r_trunc;

    stream_parity_gen #(.WIDTH(8), .ODD(1'b1), .MAX_WORDS(16)) u2 (
        .clk(clk), .rst(rst), .in_data(r_in_data), .in_valid(r_in_valid), .in_last(r_in_last),
        .in_ready(r_rdy), .out_data(r_dat), .out_par(r_par), .out_valid(r_vld),
        .out_ready(r_out_ready), .out_last(r_last), .out_trailer(r_trl), .out_trunc(r_trunc));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst, iv;
        logic [7:0] id;
        logic       il, ordy;
        logic       x_rdy, x_vld;
        logic [7:0] x_data;
        logic       x_par;
        logic [2:0] x_flags;  // {last, trailer, trunc}
        logic       x_all;
        logic       e_chk;
        logic [7:0] e_data;
        logic       e_par;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic iv, logic [7:0] id, logic il, logic ordy,
                               logic x_rdy, logic x_vld, logic [7:0] x_data, logic x_par,
                               logic [2:0] x_flags, logic x_all,
                               logic e_chk, logic [7:0] e_data, logic e_par);
        vec_t t;
        t.rst = r; t.iv = iv; t.id = id; t.il = il; t.ordy = ordy;
        t.x_rdy = x_rdy; t.x_vld = x_vld; t.x_data = x_data; t.x_par = x_par;
        t.x_flags = x_flags; t.x_all = x_all;
        t.e_chk = e_chk; t.e_data = e_data; t.e_par = e_par;
        return t;
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       last;
    } word_t;

    typedef struct {
        logic [7:0] data;
        logic       par, last, trailer, trunc;
    } exp_t;

    word_t words[$];
    exp_t  exp_q[$];

    initial begin
        rst = 1'b1; in_valid = 0; in_data = 0; in_last = 0; out_ready = 1;
        r_in_valid = 0; r_in_data = 0; r_in_last = 0; r_out_ready = 1;

        // rst iv  id     il ordy| rdy vld data  par flags  all | even instance
        tbl.push_back(v(1,1,8'hAA,0,1, 0,0,8'h00,1,3'b000,1, 1,8'h00,0));  // reset
        tbl.push_back(v(0,1,8'h01,0,1, 1,1,8'h01,0,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,1,8'h02,0,1, 1,1,8'h02,0,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,1,8'h04,1,1, 1,1,8'h04,0,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,0,8'h00,0,1, 0,1,8'hF8,0,3'b110,0, 0,8'h00,0));
        tbl.push_back(v(0,0,8'h00,0,1, 1,0,8'h00,0,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,1,8'h00,1,1, 1,1,8'h00,1,3'b000,0, 1,8'h00,0));  // single zero word
        tbl.push_back(v(0,0,8'h00,0,1, 0,1,8'hFF,1,3'b110,0, 1,8'h00,0));
        tbl.push_back(v(0,0,8'h00,0,1, 1,0,8'h00,0,3'b000,0, 0,8'h00,0));
        for (int k = 0; k < 4; k++)                                        // truncated frame
            tbl.push_back(v(0,1,8'h11,0,1, 1,1,8'h11,1,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,1,8'h11,1,1, 0,1,8'hFF,1,3'b111,0, 0,8'h00,0));
        tbl.push_back(v(0,1,8'h11,1,1, 1,1,8'h11,1,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,0,8'h00,0,1, 0,1,8'hEE,1,3'b110,0, 0,8'h00,0));
        tbl.push_back(v(0,0,8'h00,0,1, 1,0,8'h00,0,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,1,8'h80,0,1, 1,1,8'h80,0,3'b000,0, 0,8'h00,0));  // last on word MAX
        tbl.push_back(v(0,1,8'h40,0,1, 1,1,8'h40,0,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,1,8'h20,0,1, 1,1,8'h20,0,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,1,8'h10,1,1, 1,1,8'h10,0,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,0,8'h00,0,1, 0,1,8'h0F,1,3'b110,0, 0,8'h00,0));
        tbl.push_back(v(0,0,8'h00,0,1, 1,0,8'h00,0,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,1,8'h05,0,1, 1,1,8'h05,1,3'b000,0, 0,8'h00,0));  // 3-cycle stall
        for (int k = 0; k < 3; k++)
            tbl.push_back(v(0,1,8'h06,0,0, 0,1,8'h05,1,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,1,8'h06,0,1, 1,1,8'h06,1,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,1,8'h07,1,1, 1,1,8'h07,0,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,0,8'h00,0,1, 0,1,8'hFB,0,3'b110,0, 0,8'h00,0));
        tbl.push_back(v(0,0,8'h00,0,1, 1,0,8'h00,0,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,1,8'h09,0,1, 1,1,8'h09,1,3'b000,0, 0,8'h00,0));  // reset mid-frame
        tbl.push_back(v(0,1,8'h0A,0,1, 1,1,8'h0A,1,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,0,8'h00,0,0, 0,1,8'h0A,1,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(1,1,8'h0B,0,0, 0,0,8'h00,1,3'b000,1, 1,8'h00,0));
        tbl.push_back(v(0,1,8'h03,1,1, 1,1,8'h03,1,3'b000,0, 0,8'h00,0));
        tbl.push_back(v(0,0,8'h00,0,1, 0,1,8'hFC,1,3'b110,0, 0,8'h00,0));
        tbl.push_back(v(0,0,8'h00,0,1, 1,0,8'h00,0,3'b000,0, 0,8'h00,0));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].id;
            in_last = tbl[i].il; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("row%0d in_ready", i), 32'(rdy0), 32'(tbl[i].x_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d out_valid", i), 32'(vld0), 32'(tbl[i].x_vld));
            if (tbl[i].x_vld || tbl[i].x_all) begin
                chk($sformatf("row%0d out_data", i), 32'(dat0), 32'(tbl[i].x_data));
                chk($sformatf("row%0d out_par", i), 32'(par0), 32'(tbl[i].x_par));
                chk($sformatf("row%0d flags", i), 32'({last0, trl0, trunc0}), 32'(tbl[i].x_flags));
            end
            if (tbl[i].e_chk) begin
                chk($sformatf("row%0d even out_data", i), 32'(dat1), 32'(tbl[i].e_data));
                chk($sformatf("row%0d even out_par", i), 32'(par1), 32'(tbl[i].e_par));
            end
        end

        // Random frames of 1..20 words against a scoreboard.
        @(negedge clk);
        rst = 0; in_valid = 0; out_ready = 1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                word_t w;
                w.data = 8'($urandom);
                w.last = (k == len - 1);
                words.push_back(w);
            end
        end

        begin
            int         wi = 0;
            int         cyc = 0;
            int         m_cnt = 0;
            logic [7:0] m_acc = 8'h00;
            while ((wi < words.size() || exp_q.size() != 0) && cyc < 20000) begin
                @(negedge clk);
                cyc++;
                r_in_valid  = (wi < words.size()) && ($urandom_range(0, 2) != 0);
                r_in_data   = (wi < words.size()) ? words[wi].data : 8'h00;
                r_in_last   = (wi < words.size()) ? words[wi].last : 1'b0;
                r_out_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (r_vld && r_out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("rnd unexpected word", 32'(r_vld), 32'(0));
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("rnd out_data", 32'(r_dat), 32'(e.data));
                        chk("rnd out_par", 32'(r_par), 32'(e.par));
                        chk("rnd flags", 32'({r_last, r_trl, r_trunc}),
                            32'({e.last, e.trailer, e.trunc}));
                    end
                end
                if (r_in_valid && r_rdy) begin
                    exp_t e;
                    e.data = r_in_data; e.par = ~^r_in_data;
                    e.last = 0; e.trailer = 0; e.trunc = 0;
                    exp_q.push_back(e);
                    m_acc = m_acc ^ r_in_data;
                    m_cnt++;
                    if (r_in_last || m_cnt == 16) begin
                        e.data = ~m_acc; e.par = ~^(~m_acc);
                        e.last = 1; e.trailer = 1; e.trunc = !r_in_last;
                        exp_q.push_back(e);
                        m_acc = 8'h00;
                        m_cnt = 0;
                    end
                    wi++;
                end
                @(posedge clk);
            end
            if (cyc >= 20000) begin
                errors++;
                $display("FAIL rnd timeout: got %0d words pending expected 0", exp_q.size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_parity_gen.md
# stream_parity_gen

Streaming parity generator, parametrised in word width and parity sense, for the data paths behind the team's combinational parity helpers. It accepts words on a valid/ready stream and outputs each word with its per-word parity bit. After each frame it inserts one trailer word carrying the frame's column parity (LRC). Frames that reach a maximum length are force-closed and flagged as truncated.

## Interface

- WIDTH, 8, data word width in bits (≥1)
- ODD, 1, 1 = odd parity, 0 = even parity; applies to the per-word bit and the trailer
- MAX_WORDS, 16, maximum data words per frame (≥1); counter width is $clog2(MAX_WORDS+1)
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  data word
- in_valid  input  1  in_data is valid
- in_last  input  1  word is the last data word of the frame
- in_ready  output  1  block accepts a word this cycle
- out_data  output  WIDTH  data word or trailer LRC
- out_par  output  1  parity bit over out_data
- out_valid  output  1  output register holds a word
- out_ready  input  1  downstream accepts the word this cycle
- out_last  output  1  asserted only on the trailer word
- out_trailer  output  1  out_data is the trailer LRC, not data
- out_trunc  output  1  trailer closes a frame that was force-ended at MAX_WORDS

## Operation

- Accept: in_valid && in_ready. Emit: out_valid && out_ready.
- Slot free: !out_valid || out_ready.
- Per-word parity: out_par = ^out_data when ODD=0; out_par = ~^out_data when ODD=1.
- State PASS:
  - in_ready = slot free; in_ready is 0 while rst=1.
  - On accept, load the output register: out_data=in_data, out_last=0, out_trailer=0, out_trunc=0.
  - On accept, update: acc ^= in_data, cnt += 1.
- Frame close, on accept when in_last=1 or cnt==MAX_WORDS-1:
  - Latch trl = acc ^ in_data, inverted when ODD=1.
  - Latch trunc = !in_last. in_last on word MAX_WORDS is a normal close with trunc=0.
  - Clear acc and cnt; go to TRAILER.
- State TRAILER:
  - in_ready = 0.
  - When slot free, load the output register: out_data=trl, out_last=1, out_trailer=1, out_trunc=trunc. Go to PASS.
- out_par on the trailer uses the same rule as data words; the trailer itself satisfies the chosen parity sense.
- A word offered after a truncated close starts a new frame. Its in_last is honoured normally.
- Held words are stable: while out_valid && !out_ready, all out_* hold their values.
- Reset mid-frame or mid-trailer: the partial frame and any pending trailer are discarded; no trailer is emitted.

## Timing

- Reset values:
  - out_valid=0, out_data=0, out_par = (ODD ? 1 : 0), out_last=0, out_trailer=0, out_trunc=0.
  - in_ready=0 during rst; state=PASS, acc=0, cnt=0, trl=0, trunc=0.
- Latency: accepted word appears on out_* the next cycle.
- Throughput: 1 word/cycle with out_ready held high. A frame of N words takes N+1 output cycles; the cycle after a close has in_ready=0.
- in_ready depends combinationally on out_ready and state only. It never depends on in_valid.
- Backpressure: no word is lost or duplicated for any out_ready pattern.

## Test plan

- WIDTH=8, ODD=1, out_ready=1; frame 0x01, 0x02, 0x04 (last on 0x04):
  - Outputs (data,par) = (0x01,0),(0x02,0),(0x04,0); all have out_last=0.
  - Then trailer 0xF8, par=0, out_last=1, out_trailer=1, out_trunc=0.
  - in_ready=0 for exactly one cycle.
- ODD=1, single-word frame 0x00 with last:
  - Output (0x00,1), then trailer 0xFF, par=1.
  - ODD=0, same frame: (0x00,0), then trailer 0x00, par=0.
- MAX_WORDS=4, ODD=1; five words 0x11, none with last:
  - After word 4: trailer 0xFF, out_trunc=1.
  - Word 5 starts a new frame; giving it last yields (0x11,1), then trailer 0xEE, par=1.
- Backpressure: mid-frame, drop out_ready for 3 cycles with in_valid=1:
  - out_* hold, in_ready=0.
  - On release, sequence and trailer match the no-stall run.
- Reset: assert rst for 1 cycle after 2 words of a frame, while the 2nd word is held under backpressure:
  - Next cycle all outputs are at reset values.
  - A new frame 0x03 (last) gives (0x03,1), then trailer 0xFC, par=1; no stale trailer appears.
- Random: random in_valid/out_ready, random frame lengths 1–20 with MAX_WORDS=16:
  - A scoreboard checks every parity bit, every LRC, trunc flags and word ordering.
